// File: rtl/axi_pipe_pkg.sv
// Shared channel indices, depth limit and default AXI beat/bundle types.
// Latency, backpressure and reset behaviour are defined by the modules that use these types.
package axi_pipe_pkg;

  localparam int AW = 0;
  localparam int W  = 1;
  localparam int B  = 2;
  localparam int AR = 3;
  localparam int R  = 4;

  localparam int NumChan  = 5;
  localparam int MaxDepth = 1024;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } aw_beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_beat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_beat_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } ar_beat_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_beat_t;

  typedef struct packed {
    aw_beat_t aw;
    logic     aw_valid;
    w_beat_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_beat_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    b_beat_t  b;
    logic     b_valid;
    logic     ar_ready;
    r_beat_t  r;
    logic     r_valid;
  } resp_t;

endpackage

// File: rtl/axi_chan_fifo.sv
// One AXI channel buffer: Depth 0 is a zero-latency wire, Depth>=1 a FIFO with 1-cycle latency.
// Backpressure: ready_o = !full, never passes through when full; rst_i forces valid_o/ready_o low.
module axi_chan_fifo import axi_pipe_pkg::*; #(
  parameter type T     = logic,
  parameter int  Depth = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  if (Depth < 0 || Depth > MaxDepth) begin : g_bad_depth
    $error("axi_chan_fifo: Depth %0d outside 0..%0d", Depth, MaxDepth);
  end

  if (Depth == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;

    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign full_o  = 1'b0;
    assign empty_o = 1'b1;
  end else begin : g_fifo
    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

    T                mem [Depth];
    logic [CntW-1:0] cnt;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic            push;
    logic            pop;

    assign full_o  = (cnt == CntFull);
    assign empty_o = (cnt == '0);
    assign ready_o = !full_o && !rst_i;
    assign valid_o = !empty_o && !rst_i;
    assign data_o  = mem[rd_ptr];
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end

    // Storage is left unreset; only the read pointer moves data_o, which keeps it stable until popped.
    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/axi_fifo_pipeline.sv
// Per-channel elastic buffering between a crossbar port and a slave; each depth independently sized.
// Latency 0 (depth 0) or 1 (depth>=1) per channel; each channel backpressures on its own full flag.
module axi_fifo_pipeline import axi_pipe_pkg::*; #(
  // Depth 0 = combinational bypass. Depth 1 accepts one beat every other cycle because a full
  // buffer never passes through; depth >= 2 sustains one beat per cycle.
  parameter int  AwDepth    = 2,
  parameter int  WDepth     = 2,
  parameter int  BDepth     = 2,
  parameter int  ArDepth    = 2,
  parameter int  RDepth     = 2,
  parameter type aw_chan_t  = aw_beat_t,
  parameter type w_chan_t   = w_beat_t,
  parameter type b_chan_t   = b_beat_t,
  parameter type ar_chan_t  = ar_beat_t,
  parameter type r_chan_t   = r_beat_t,
  parameter type axi_req_t  = req_t,
  parameter type axi_resp_t = resp_t
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  axi_req_t           slv_req_i,
  output axi_resp_t          slv_resp_o,
  output axi_req_t           mst_req_o,
  input  axi_resp_t          mst_resp_i,
  output logic               idle_o,
  output logic [NumChan-1:0] full_o
);

  logic [NumChan-1:0] full_vec;
  logic [NumChan-1:0] empty_vec;

  logic     aw_up_rdy, aw_dn_vld;
  aw_chan_t aw_dn_dat;
  logic     w_up_rdy, w_dn_vld;
  w_chan_t  w_dn_dat;
  logic     b_up_rdy, b_dn_vld;
  b_chan_t  b_dn_dat;
  logic     ar_up_rdy, ar_dn_vld;
  ar_chan_t ar_dn_dat;
  logic     r_up_rdy, r_dn_vld;
  r_chan_t  r_dn_dat;

  axi_chan_fifo #(.T(aw_chan_t), .Depth(AwDepth)) i_aw_fifo (
    .clk_i, .rst_i,
    .valid_i(slv_req_i.aw_valid), .ready_o(aw_up_rdy), .data_i(slv_req_i.aw),
    .valid_o(aw_dn_vld), .ready_i(mst_resp_i.aw_ready), .data_o(aw_dn_dat),
    .full_o(full_vec[AW]), .empty_o(empty_vec[AW])
  );

  axi_chan_fifo #(.T(w_chan_t), .Depth(WDepth)) i_w_fifo (
    .clk_i, .rst_i,
    .valid_i(slv_req_i.w_valid), .ready_o(w_up_rdy), .data_i(slv_req_i.w),
    .valid_o(w_dn_vld), .ready_i(mst_resp_i.w_ready), .data_o(w_dn_dat),
    .full_o(full_vec[W]), .empty_o(empty_vec[W])
  );

  // Response channels run in the opposite direction: producer is the downstream slave.
  axi_chan_fifo #(.T(b_chan_t), .Depth(BDepth)) i_b_fifo (
    .clk_i, .rst_i,
    .valid_i(mst_resp_i.b_valid), .ready_o(b_up_rdy), .data_i(mst_resp_i.b),
    .valid_o(b_dn_vld), .ready_i(slv_req_i.b_ready), .data_o(b_dn_dat),
    .full_o(full_vec[B]), .empty_o(empty_vec[B])
  );

  axi_chan_fifo #(.T(ar_chan_t), .Depth(ArDepth)) i_ar_fifo (
    .clk_i, .rst_i,
    .valid_i(slv_req_i.ar_valid), .ready_o(ar_up_rdy), .data_i(slv_req_i.ar),
    .valid_o(ar_dn_vld), .ready_i(mst_resp_i.ar_ready), .data_o(ar_dn_dat),
    .full_o(full_vec[AR]), .empty_o(empty_vec[AR])
  );

  axi_chan_fifo #(.T(r_chan_t), .Depth(RDepth)) i_r_fifo (
    .clk_i, .rst_i,
    .valid_i(mst_resp_i.r_valid), .ready_o(r_up_rdy), .data_i(mst_resp_i.r),
    .valid_o(r_dn_vld), .ready_i(slv_req_i.r_ready), .data_o(r_dn_dat),
    .full_o(full_vec[R]), .empty_o(empty_vec[R])
  );

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = aw_dn_dat;
    mst_req_o.aw_valid = aw_dn_vld;
    mst_req_o.w        = w_dn_dat;
    mst_req_o.w_valid  = w_dn_vld;
    mst_req_o.b_ready  = b_up_rdy;
    mst_req_o.ar       = ar_dn_dat;
    mst_req_o.ar_valid = ar_dn_vld;
    mst_req_o.r_ready  = r_up_rdy;

    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_up_rdy;
    slv_resp_o.w_ready  = w_up_rdy;
    slv_resp_o.b        = b_dn_dat;
    slv_resp_o.b_valid  = b_dn_vld;
    slv_resp_o.ar_ready = ar_up_rdy;
    slv_resp_o.r        = r_dn_dat;
    slv_resp_o.r_valid  = r_dn_vld;
  end

  // Bypassed channels report empty and never full, so they drop out of both status outputs.
  assign idle_o = &empty_vec;
  assign full_o = full_vec;

endmodule

// File: tb/tb_axi_fifo_pipeline.sv
// Directed table/sequences plus a randomized run checked against a list-based channel model.
module tb_axi_fifo_pipeline;
  import axi_pipe_pkg::*;

  localparam int AwD = 2, WD = 3, BD = 1, ArD = 0, RD = 2;
  localparam int Dep [NumChan] = '{AwD, WD, BD, ArD, RD};

  logic               clk = 1'b0;
  logic               rst;
  req_t               slv_req, mst_req;
  resp_t              slv_resp, mst_resp;
  logic               idle;
  logic [NumChan-1:0] full;

  always #5 clk = ~clk;

  axi_fifo_pipeline #(
    .AwDepth(AwD), .WDepth(WD), .BDepth(BD), .ArDepth(ArD), .RDepth(RD)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp),
    .idle_o(idle), .full_o(full)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Uniform per-channel view: "in" is the producer side, "out" the consumer side.
  logic [NumChan-1:0] in_vld, in_rdy, out_vld, out_rdy;
  logic [63:0]        in_dat  [NumChan];
  logic [63:0]        out_dat [NumChan];

  always_comb begin
    in_vld = '0; in_rdy = '0; out_vld = '0; out_rdy = '0;
    in_vld[AW] = slv_req.aw_valid;  in_rdy[AW] = slv_resp.aw_ready; in_dat[AW] = 64'(slv_req.aw);
    out_vld[AW] = mst_req.aw_valid; out_rdy[AW] = mst_resp.aw_ready; out_dat[AW] = 64'(mst_req.aw);
    in_vld[W] = slv_req.w_valid;    in_rdy[W] = slv_resp.w_ready;   in_dat[W] = 64'(slv_req.w);
    out_vld[W] = mst_req.w_valid;   out_rdy[W] = mst_resp.w_ready;  out_dat[W] = 64'(mst_req.w);
    in_vld[B] = mst_resp.b_valid;   in_rdy[B] = mst_req.b_ready;    in_dat[B] = 64'(mst_resp.b);
    out_vld[B] = slv_resp.b_valid;  out_rdy[B] = slv_req.b_ready;   out_dat[B] = 64'(slv_resp.b);
    in_vld[AR] = slv_req.ar_valid;  in_rdy[AR] = slv_resp.ar_ready; in_dat[AR] = 64'(slv_req.ar);
    out_vld[AR] = mst_req.ar_valid; out_rdy[AR] = mst_resp.ar_ready; out_dat[AR] = 64'(mst_req.ar);
    in_vld[R] = mst_resp.r_valid;   in_rdy[R] = mst_req.r_ready;    in_dat[R] = 64'(mst_resp.r);
    out_vld[R] = slv_resp.r_valid;  out_rdy[R] = slv_req.r_ready;   out_dat[R] = 64'(slv_resp.r);
  end

  logic [NumChan-1:0] drv_vld, drv_rdy;
  logic [63:0]        drv_dat [NumChan];

  task automatic apply();
    slv_req  = '0;
    mst_resp = '0;
    slv_req.aw_valid  = drv_vld[AW]; slv_req.aw = aw_beat_t'(drv_dat[AW][$bits(aw_beat_t)-1:0]);
    mst_resp.aw_ready = drv_rdy[AW];
    slv_req.w_valid   = drv_vld[W];  slv_req.w  = w_beat_t'(drv_dat[W][$bits(w_beat_t)-1:0]);
    mst_resp.w_ready  = drv_rdy[W];
    mst_resp.b_valid  = drv_vld[B];  mst_resp.b = b_beat_t'(drv_dat[B][$bits(b_beat_t)-1:0]);
    slv_req.b_ready   = drv_rdy[B];
    slv_req.ar_valid  = drv_vld[AR]; slv_req.ar = ar_beat_t'(drv_dat[AR][$bits(ar_beat_t)-1:0]);
    mst_resp.ar_ready = drv_rdy[AR];
    mst_resp.r_valid  = drv_vld[R];  mst_resp.r = r_beat_t'(drv_dat[R][$bits(r_beat_t)-1:0]);
    slv_req.r_ready   = drv_rdy[R];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each buffered channel is an ordered list of held beats.
  logic [63:0] mq [NumChan][4];
  int          mcnt [NumChan];

  task automatic model_step();
    logic               exp_idle;
    logic [NumChan-1:0] exp_full;
    logic               exp_rdy, exp_vld;
    exp_idle = 1'b1;
    exp_full = '0;
    for (int c = 0; c < NumChan; c++) begin
      if (Dep[c] > 0 && mcnt[c] != 0) exp_idle = 1'b0;
      if (Dep[c] > 0 && mcnt[c] == Dep[c]) exp_full[c] = 1'b1;
    end
    chk("idle", idle, exp_idle);
    chk("full", full, exp_full);
    for (int c = 0; c < NumChan; c++) begin
      if (Dep[c] == 0) begin
        chk($sformatf("pass_vld[%0d]", c), out_vld[c], in_vld[c]);
        chk($sformatf("pass_rdy[%0d]", c), in_rdy[c], out_rdy[c]);
        if (in_vld[c]) chk($sformatf("pass_dat[%0d]", c), out_dat[c], in_dat[c]);
      end else begin
        exp_rdy = (mcnt[c] < Dep[c]);
        exp_vld = (mcnt[c] > 0);
        chk($sformatf("rdy[%0d]", c), in_rdy[c], exp_rdy);
        chk($sformatf("vld[%0d]", c), out_vld[c], exp_vld);
        if (exp_vld) chk($sformatf("dat[%0d]", c), out_dat[c], mq[c][0]);
        if (exp_vld && out_rdy[c]) begin
          for (int j = 0; j < 3; j++) mq[c][j] = mq[c][j+1];
          mcnt[c]--;
        end
        if (in_vld[c] && exp_rdy) begin
          mq[c][mcnt[c]] = in_dat[c];
          mcnt[c]++;
        end
      end
    end
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        rdy;
    logic        e_in_rdy;
    logic        e_out_vld;
    logic [31:0] e_dat;
    logic        e_full;
  } wvec_t;

  wvec_t              wt [9];
  logic [NumChan-1:0] accepted;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // W channel (depth 3): fill, refuse while full even with a pop, then drain across the wrap.
    wt[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
    wt[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0};
    wt[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b0};
    wt[3] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b1};
    wt[4] = '{1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b1};
    wt[5] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b0};
    wt[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2, 1'b0};
    wt[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA3, 1'b0};
    wt[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0};

    for (int c = 0; c < NumChan; c++) drv_dat[c] = '0;
    rst = 1'b1;
    drv_vld = '1;
    drv_rdy = '1;
    drv_dat[AR] = 64'h5_0000_2000;
    apply();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_aw_ready", slv_resp.aw_ready, 1'b0);
    chk("rst_w_ready", slv_resp.w_ready, 1'b0);
    chk("rst_aw_valid", mst_req.aw_valid, 1'b0);
    chk("rst_w_valid", mst_req.w_valid, 1'b0);
    chk("rst_b_valid", slv_resp.b_valid, 1'b0);
    chk("rst_b_ready", mst_req.b_ready, 1'b0);
    chk("rst_r_valid", slv_resp.r_valid, 1'b0);
    chk("rst_r_ready", mst_req.r_ready, 1'b0);
    chk("rst_ar_pass", mst_req.ar_valid, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_full", full, 5'b00000);
    tick();
    rst = 1'b0;
    drv_vld = '0;
    drv_rdy = '0;
    apply();
    @(negedge clk);
    chk("post_rst_aw_ready", slv_resp.aw_ready, 1'b1);
    chk("post_rst_idle", idle, 1'b1);
    chk("post_rst_full", full, 5'b00000);

    // Single AW beat: appears downstream exactly one cycle after the push.
    tick();
    drv_vld[AW] = 1'b1; drv_dat[AW] = 64'h1000; drv_rdy[AW] = 1'b1;
    apply();
    @(negedge clk);
    chk("aw_push_ready", slv_resp.aw_ready, 1'b1);
    chk("aw_push_cycle_valid", mst_req.aw_valid, 1'b0);
    chk("aw_push_cycle_idle", idle, 1'b1);
    tick();
    drv_vld[AW] = 1'b0;
    apply();
    @(negedge clk);
    chk("aw_out_valid", mst_req.aw_valid, 1'b1);
    chk("aw_out_addr", mst_req.aw.addr, 32'h1000);
    chk("aw_busy_idle", idle, 1'b0);
    tick();
    @(negedge clk);
    chk("aw_after_valid", mst_req.aw_valid, 1'b0);
    chk("aw_after_idle", idle, 1'b1);

    for (int i = 0; i < 9; i++) begin
      tick();
      drv_vld[W] = wt[i].vld;
      drv_dat[W] = {31'b0, wt[i].dat, 1'b0};
      drv_rdy[W] = wt[i].rdy;
      apply();
      @(negedge clk);
      chk($sformatf("w%0d_in_ready", i), slv_resp.w_ready, wt[i].e_in_rdy);
      chk($sformatf("w%0d_out_valid", i), mst_req.w_valid, wt[i].e_out_vld);
      chk($sformatf("w%0d_full", i), full[W], wt[i].e_full);
      if (wt[i].e_out_vld) chk($sformatf("w%0d_data", i), mst_req.w.data, wt[i].e_dat);
    end
    drv_vld[W] = 1'b0; drv_rdy[W] = 1'b0;

    // R (depth 2): 20 back-to-back beats stream through with no bubbles.
    drv_rdy[R] = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick();
      drv_vld[R] = (i < 20);
      drv_dat[R] = 64'(100 + i) << 3;
      apply();
      @(negedge clk);
      chk($sformatf("r%0d_ready", i), mst_req.r_ready, 1'b1);
      chk($sformatf("r%0d_valid", i), slv_resp.r_valid, i != 0);
      if (i != 0) begin
        chk($sformatf("r%0d_data", i), slv_resp.r.data, 32'(100 + i - 1));
        chk($sformatf("r%0d_idle", i), idle, 1'b0);
        chk($sformatf("r%0d_full", i), full[R], 1'b0);
      end
    end
    tick();
    drv_vld[R] = 1'b0;
    drv_rdy[R] = 1'b0;
    apply();
    @(negedge clk);
    chk("r_drained_valid", slv_resp.r_valid, 1'b0);

    // B (depth 1): accepts every other cycle, ids in order.
    drv_rdy[B] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      drv_vld[B] = 1'b1;
      drv_dat[B] = 64'(k / 2 + 1) << 2;
      apply();
      @(negedge clk);
      chk($sformatf("b%0d_ready", k), mst_req.b_ready, (k % 2) == 0);
      chk($sformatf("b%0d_valid", k), slv_resp.b_valid, (k % 2) == 1);
      chk($sformatf("b%0d_full", k), full[B], (k % 2) == 1);
      if (k % 2 == 1) chk($sformatf("b%0d_id", k), slv_resp.b.id, 4'(k / 2 + 1));
    end
    tick();
    drv_vld[B] = 1'b0; drv_rdy[B] = 1'b0;
    apply();

    // AR (depth 0): same-cycle pass-through, never full.
    tick();
    drv_vld[AR] = 1'b1; drv_dat[AR] = 64'h5_0000_2000; drv_rdy[AR] = 1'b0;
    apply();
    @(negedge clk);
    chk("ar_valid", mst_req.ar_valid, 1'b1);
    chk("ar_id", mst_req.ar.id, 4'd5);
    chk("ar_ready_low", slv_resp.ar_ready, 1'b0);
    chk("ar_full_a", full[AR], 1'b0);
    tick();
    drv_rdy[AR] = 1'b1;
    apply();
    @(negedge clk);
    chk("ar_ready_high", slv_resp.ar_ready, 1'b1);
    chk("ar_full_b", full[AR], 1'b0);
    tick();
    drv_vld[AR] = 1'b0; drv_rdy[AR] = 1'b0;
    apply();

    // Reset with two W beats buffered: they are dropped.
    tick();
    drv_vld[W] = 1'b1; drv_dat[W] = {31'b0, 32'hB0, 1'b0};
    apply();
    tick();
    drv_dat[W] = {31'b0, 32'hB1, 1'b0};
    apply();
    tick();
    drv_vld[W] = 1'b0;
    apply();
    @(negedge clk);
    chk("wrst_pre_valid", mst_req.w_valid, 1'b1);
    chk("wrst_pre_idle", idle, 1'b0);
    tick();
    rst = 1'b1;
    drv_rdy[W] = 1'b1;
    apply();
    @(negedge clk);
    chk("wrst_during_valid", mst_req.w_valid, 1'b0);
    chk("wrst_during_ready", slv_resp.w_ready, 1'b0);
    tick();
    rst = 1'b0;
    apply();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("wrst_after%0d_valid", i), mst_req.w_valid, 1'b0);
      chk($sformatf("wrst_after%0d_idle", i), idle, 1'b1);
      tick();
    end

    // Randomized traffic on all channels against the model, starting from reset.
    rst = 1'b1;
    drv_vld = '0; drv_rdy = '0;
    apply();
    tick();
    rst = 1'b0;
    for (int c = 0; c < NumChan; c++) mcnt[c] = 0;
    accepted = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NumChan; c++) begin
        if (!drv_vld[c] || accepted[c]) begin
          drv_vld[c] = ($urandom_range(0, 2) != 0);
          drv_dat[c] = {$urandom(), $urandom()};
        end
        drv_rdy[c] = (k < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end
      apply();
      @(negedge clk);
      accepted = in_vld & in_rdy;
      model_step();
      tick();
    end
    drv_vld = '0; drv_rdy = '1;
    apply();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      model_step();
      tick();
    end
    @(negedge clk);
    chk("drain_idle", idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
